// File: rtl/response_checker_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : response_checker_pkg
// Brief  : Shared types and constants for the response checker.
// Rev    : 1.0
//------------------------------------------------------------------------------
package response_checker_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] resp_t;

  // Golden {D,E} for vector index idx, packed two bits per entry.
  function automatic resp_t lookup_exp(input logic [15:0] tbl, input logic [2:0] idx);
    return tbl[{idx, 1'b0} +: 2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/response_checker_sat_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : sat_counter
// Brief  : Up-counter with synchronous clear that holds at all-ones.
// Rev    : 1.0
//------------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/response_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : response_checker
// Brief  : Compares DUT {D,E} responses against a golden table over a run of
//          NUM_VEC vectors. Optional macro RESPONSE_CHECKER_COVERAGE_EN adds
//          the cov_map output.
// Rev    : 1.0
//------------------------------------------------------------------------------
module response_checker
  import response_checker_pkg::*;
#(
  parameter logic [15:0] EXP_TABLE = 16'h0000,
  parameter int          NUM_VEC   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [2:0]       vec_abc,
  input  logic             resp_d,
  input  logic             resp_e,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [4:0]       first_fail
`ifdef RESPONSE_CHECKER_COVERAGE_EN
  ,
  output logic [7:0]       cov_map
`endif
);

  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(NUM_VEC - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_clear;
  logic             w_accept;
  logic             w_mismatch;
  resp_t            w_resp;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [4:0]       r_first_fail;
  logic [CNT_W-1:0] w_err_cnt;

  assign w_resp     = {resp_d, resp_e};
  assign w_mismatch = w_accept && (w_resp != lookup_exp(EXP_TABLE, vec_abc));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // start outranks a coincident vec_valid in every state.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next_state = RUN;
          w_clear      = 1'b1;
        end
      end
      RUN: begin
        if (start) begin
          w_clear = 1'b1;
        end else if (vec_valid) begin
          w_accept = 1'b1;
          if (r_vec_cnt == c_last_idx) begin
            w_next_state = DONE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_vec_cnt    <= '0;
      r_first_fail <= '0;
    end else if (w_accept) begin
      r_vec_cnt <= r_vec_cnt + 1'b1;
      if (w_mismatch && (w_err_cnt == '0)) begin
        r_first_fail <= {vec_abc, resp_d, resp_e};
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .inc   (w_mismatch),
    .count (w_err_cnt)
  );

`ifdef RESPONSE_CHECKER_COVERAGE_EN
  logic [7:0] r_cov_map;

  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_cov_map <= '0;
    end else if (w_accept) begin
      r_cov_map[vec_abc] <= 1'b1;
    end
  end

  assign cov_map = r_cov_map;
`endif

  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign pass       = done && (w_err_cnt == '0);
  assign vec_cnt    = r_vec_cnt;
  assign err_cnt    = w_err_cnt;
  assign first_fail = r_first_fail;

endmodule
`default_nettype wire

// File: doc/response_checker.md
RESPONSE_CHECKER -- requirements
Module: response_checker

Interface
REQ-001 Parameter EXP_TABLE, default 16'h0000, golden response table; bits [2i+1:2i] = expected {D,E} for input vector index i = {A,B,C}.
REQ-002 Parameter NUM_VEC, default 8, number of vectors per run, legal range 1..255.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a run.
REQ-006 vec_valid  input  1  applied vector and DUT response valid this cycle.
REQ-007 vec_abc  input  3  applied vector {A,B,C}.
REQ-008 resp_d  input  1  DUT output D.
REQ-009 resp_e  input  1  DUT output E.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high from run completion until next start or reset.
REQ-012 pass  output  1  valid when done; high iff err_cnt == 0.
REQ-013 vec_cnt  output  8  vectors checked this run.
REQ-014 err_cnt  output  8  mismatches this run, saturating at 255.
REQ-015 first_fail  output  5  {vec_abc, resp_d, resp_e} of first mismatch; zero if none.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE -> RUN on start; RUN -> DONE on acceptance of the NUM_VEC-th vector; DONE -> RUN on start.
REQ-017 Entering RUN clears vec_cnt, err_cnt, first_fail, done, pass in the same edge that samples start.
REQ-018 In RUN, vec_valid high on edge t: vector accepted; vec_cnt, err_cnt, first_fail updated at edge t (visible cycle t+1).
REQ-019 Mismatch: {resp_d,resp_e} != EXP_TABLE[2*vec_abc +: 2]; err_cnt increments by 1, holds at 255.
REQ-020 first_fail captured only on the first mismatch of a run; later mismatches leave it unchanged.
REQ-021 busy = (state == RUN); done = (state == DONE); pass = done && err_cnt == 0.
REQ-022 Last vector and its mismatch are counted before done rises; done and final counts appear in the same cycle.
REQ-023 vec_valid outside RUN is ignored; no counter changes.
REQ-024 start while in RUN restarts the run: counters cleared, state stays RUN.
REQ-025 start and vec_valid in the same cycle: start wins; that vector is not counted.

Reset
REQ-026 reset high at an edge forces IDLE, busy=0, done=0, pass=0, vec_cnt=0, err_cnt=0, first_fail=0, overriding start and vec_valid, including mid-run.

Configuration
REQ-027 Macro RESPONSE_CHECKER_COVERAGE_EN defined: extra output cov_map [7:0], bit i set when a vector with vec_abc == i is accepted in RUN, cleared on reset and start.
REQ-028 Macro undefined: cov_map port and its logic are absent; all other behaviour identical.

Structure
REQ-029 Shared package response_checker_pkg holds the state enum (IDLE/RUN/DONE), the 2-bit response type, and constant CNT_W = 8.
REQ-030 Sub-module sat_counter (8-bit, increment/clear, saturating) instantiated for err_cnt; vec_cnt is a plain counter.

Verification
REQ-031 EXP_TABLE=16'h0000, NUM_VEC=8, start, vectors 0..7 all responding 00 -> done=1, pass=1, vec_cnt=8, err_cnt=0, first_fail=0.
REQ-032 Same setup, vector 3 answered D=1,E=0 and vector 5 answered 01 -> err_cnt=2, pass=0, first_fail=5'b011_10.
REQ-033 NUM_VEC=255, every vector answered 11 against 00 -> err_cnt 255 after vector 255, no wrap.
REQ-034 reset pulse after 4 of 8 vectors -> all outputs 0, IDLE; next 8 vectors without start -> vec_cnt stays 0.
REQ-035 start coincident with vec_valid, then 8 vectors -> vec_cnt=8 exactly; start mid-run after 3 vectors -> counts restart from 0.
REQ-036 COVERAGE_EN build, vectors 0,2,2,7 with NUM_VEC=4 -> cov_map=8'b1000_0101 at done.
